axrm_error_monitor: RTL and testbench

//  Consumes the exact and approximate product streams of the 4x4 recursive multiplier pair.

---
 rtl/axrm_pkg.sv | 15 +
 rtl/axrm_ed_stage.sv | 49 ++++
 rtl/axrm_error_monitor.sv | 159 +++++++++++++++
 tb/tb_axrm_error_monitor.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axrm_pkg.sv
// Shared types and default widths for the AxRM error monitor.
// Imported by axrm_ed_stage and axrm_error_monitor.
package axrm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } axrm_mon_state_t;

    localparam int AXRM_PROD_W = 8;
    localparam int AXRM_CNT_W  = 16;
    localparam int AXRM_SUM_W  = 24;

endpackage

// File: rtl/axrm_ed_stage.sv
// S1 register stage: absolute error distance between exact and approximate
// products, mismatch flag and valid pass-through.
module axrm_ed_stage
    import axrm_pkg::*;
#(
    parameter int PROD_W = AXRM_PROD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [PROD_W-1:0] exact_i,
    input  logic [PROD_W-1:0] approx_i,
    output logic              valid_o,
    output logic [PROD_W-1:0] ed_o,
    output logic              mism_o
);

    logic              valid_q;
    logic [PROD_W-1:0] ed_q;
    logic [PROD_W-1:0] ed_d;
    logic              mism_q;

    // Compare first so the subtraction never underflows.
    always_comb begin
        ed_d = '0;
        if (exact_i > approx_i) begin
            ed_d = exact_i - approx_i;
        end else begin
            ed_d = approx_i - exact_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ed_q    <= '0;
            mism_q  <= 1'b0;
        end else begin
            valid_q <= valid_i;
            ed_q    <= ed_d;
            mism_q  <= (ed_d != '0);
        end
    end

    assign valid_o = valid_q;
    assign ed_o    = ed_q;
    assign mism_o  = mism_q;

endmodule

// File: rtl/axrm_error_monitor.sv
// Error-statistics monitor for exact/approximate multiplier product streams.
// Optional squared-error accumulator enabled by defining AXRM_SQ_ERR_EN.
module axrm_error_monitor
    import axrm_pkg::*;
#(
    parameter int PROD_W = AXRM_PROD_W,
    parameter int CNT_W  = AXRM_CNT_W,
    parameter int SUM_W  = AXRM_SUM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_samples,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] exact_prod,
    input  logic [PROD_W-1:0] approx_prod,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [SUM_W-1:0]  sum_ed,
    output logic [PROD_W-1:0] max_ed
`ifdef AXRM_SQ_ERR_EN
    ,
    output logic [2*PROD_W+CNT_W-1:0] sum_sq_ed
`endif
);

    axrm_mon_state_t state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  sc_q, sc_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [PROD_W-1:0] max_q, max_d;
    logic [SUM_W:0]    sum_ext;

    logic              xfer;
    logic              s1_valid;
    logic [PROD_W-1:0] s1_ed;
    logic              s1_mism;

    assign in_ready = (state_q == RUN) && (acc_q < n_q);
    assign xfer     = in_valid && in_ready;

    axrm_ed_stage #(
        .PROD_W (PROD_W)
    ) u_ed (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (xfer),
        .exact_i  (exact_prod),
        .approx_i (approx_prod),
        .valid_o  (s1_valid),
        .ed_o     (s1_ed),
        .mism_o   (s1_mism)
    );

    // One spare MSB catches the carry that triggers saturation.
    assign sum_ext = {1'b0, sum_q} + (SUM_W+1)'(s1_ed);

`ifdef AXRM_SQ_ERR_EN
    localparam int SQ_W = 2*PROD_W+CNT_W;
    logic [SQ_W-1:0]     sq_q, sq_d;
    logic [2*PROD_W-1:0] ed_sq;
    logic [SQ_W:0]       sq_ext;

    assign ed_sq  = {{PROD_W{1'b0}}, s1_ed} * {{PROD_W{1'b0}}, s1_ed};
    assign sq_ext = {1'b0, sq_q} + (SQ_W+1)'(ed_sq);
`endif

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        acc_d   = acc_q;
        sc_d    = sc_q;
        err_d   = err_q;
        sum_d   = sum_q;
        max_d   = max_q;
`ifdef AXRM_SQ_ERR_EN
        sq_d    = sq_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    n_d     = num_samples;
                    acc_d   = '0;
                    sc_d    = '0;
                    err_d   = '0;
                    sum_d   = '0;
                    max_d   = '0;
`ifdef AXRM_SQ_ERR_EN
                    sq_d    = '0;
`endif
                    state_d = (num_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (xfer) begin
                    acc_d = acc_q + 1'b1;
                end
                if (s1_valid) begin
                    sc_d  = sc_q + 1'b1;
                    err_d = err_q + CNT_W'(s1_mism);
                    sum_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
                    if (s1_ed > max_q) begin
                        max_d = s1_ed;
                    end
`ifdef AXRM_SQ_ERR_EN
                    sq_d  = sq_ext[SQ_W] ? '1 : sq_ext[SQ_W-1:0];
`endif
                end
                // All accepted pairs have drained through S2.
                if (sc_q == n_q) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            acc_q   <= '0;
            sc_q    <= '0;
            err_q   <= '0;
            sum_q   <= '0;
            max_q   <= '0;
`ifdef AXRM_SQ_ERR_EN
            sq_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            acc_q   <= acc_d;
            sc_q    <= sc_d;
            err_q   <= err_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
`ifdef AXRM_SQ_ERR_EN
            sq_q    <= sq_d;
`endif
        end
    end

    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign sample_cnt = sc_q;
    assign err_cnt    = err_q;
    assign sum_ed     = sum_q;
    assign max_ed     = max_q;
`ifdef AXRM_SQ_ERR_EN
    assign sum_sq_ed  = sq_q;
`endif

endmodule

// File: tb/tb_axrm_error_monitor.sv
// Self-checking bench for axrm_error_monitor: scoreboard of expected
// statistics plus a vector table and hand-written corner sequences.
module tb_axrm_error_monitor;
    import axrm_pkg::*;

    localparam int PW  = 8;
    localparam int CW  = 16;
    localparam int SW  = 24;
    localparam int SQW = 2*PW+CW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] num_samples;
    logic          in_valid;
    logic [PW-1:0] exact_prod;
    logic [PW-1:0] approx_prod;

    logic          in_ready, busy, done;
    logic [CW-1:0] sample_cnt, err_cnt;
    logic [SW-1:0] sum_ed;
    logic [PW-1:0] max_ed;
    logic [SQW-1:0] sum_sq_ed;

    logic          in_ready2, busy2, done2;
    logic [CW-1:0] sample_cnt2, err_cnt2;
    logic [7:0]    sum_ed2;
    logic [PW-1:0] max_ed2;
    logic [SQW-1:0] sum_sq_ed2;

    axrm_error_monitor #(.PROD_W(PW), .CNT_W(CW), .SUM_W(SW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_samples (num_samples),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .exact_prod  (exact_prod),
        .approx_prod (approx_prod),
        .busy        (busy),
        .done        (done),
        .sample_cnt  (sample_cnt),
        .err_cnt     (err_cnt),
        .sum_ed      (sum_ed),
        .max_ed      (max_ed)
`ifdef AXRM_SQ_ERR_EN
        ,
        .sum_sq_ed   (sum_sq_ed)
`endif
    );

    axrm_error_monitor #(.PROD_W(PW), .CNT_W(CW), .SUM_W(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_samples (num_samples),
        .in_valid    (in_valid),
        .in_ready    (in_ready2),
        .exact_prod  (exact_prod),
        .approx_prod (approx_prod),
        .busy        (busy2),
        .done        (done2),
        .sample_cnt  (sample_cnt2),
        .err_cnt     (err_cnt2),
        .sum_ed      (sum_ed2),
        .max_ed      (max_ed2)
`ifdef AXRM_SQ_ERR_EN
        ,
        .sum_sq_ed   (sum_sq_ed2)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned     due;
        int unsigned     sc;
        int unsigned     err;
        int unsigned     sum;
        int unsigned     sum8;
        int unsigned     mx;
        longint unsigned sq;
    } exp_t;

    typedef struct {
        int ex;
        int ap;
        int err;
        int sum;
        int mx;
        int sq;
    } vec_t;

    exp_t sb[$];

    int unsigned     passes = 0;
    int unsigned     checks = 0;
    int unsigned     cyc = 0;
    int unsigned     done_at = 32'hFFFF_FFFF;
    int unsigned     acc = 0;
    int unsigned     n_m = 0;
    bit              active = 1'b0;
    int unsigned     m_sc, m_err, m_sum, m_mx;
    longint unsigned m_sq;

    task automatic chk(input string name, input longint unsigned act,
                       input longint unsigned exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_now();
        exp_t e;
        chk("in_ready", in_ready, longint'(active && acc < n_m));
        chk("busy", busy, longint'(active && cyc < done_at));
        chk("done", done, longint'(active && cyc >= done_at));
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("sample_cnt", sample_cnt, e.sc);
            chk("err_cnt", err_cnt, e.err);
            chk("sum_ed", sum_ed, e.sum);
            chk("max_ed", max_ed, e.mx);
            chk("sum_ed_sat8", sum_ed2, e.sum8);
`ifdef AXRM_SQ_ERR_EN
            chk("sum_sq_ed", sum_sq_ed, e.sq);
`endif
        end
    endtask

    task automatic push_exp(input int unsigned due);
        exp_t e;
        e.due  = due;
        e.sc   = m_sc;
        e.err  = m_err;
        e.sum  = (m_sum > 32'hFF_FFFF) ? 32'hFF_FFFF : m_sum;
        e.sum8 = (m_sum > 255) ? 255 : m_sum;
        e.mx   = m_mx;
        e.sq   = m_sq;
        sb.push_back(e);
    endtask

    task automatic drive(input bit st, input int n, input bit v,
                         input int ex, input int ap);
        int ed;
        check_now();
        start       = st;
        num_samples = CW'(n);
        in_valid    = v;
        exact_prod  = PW'(ex);
        approx_prod = PW'(ap);
        if (v && active && acc < n_m) begin
            acc++;
            ed = (ex > ap) ? ex - ap : ap - ex;
            m_sc++;
            if (ed != 0) m_err++;
            m_sum += ed;
            if (ed > int'(m_mx)) m_mx = ed;
            m_sq += longint'(ed * ed);
            push_exp(cyc + 2);
            if (acc == n_m) done_at = cyc + 3;
        end
        if (st && !(active && cyc < done_at)) begin
            active = 1'b1;
            acc    = 0;
            n_m    = n;
            m_sc   = 0;
            m_err  = 0;
            m_sum  = 0;
            m_mx   = 0;
            m_sq   = 0;
            done_at = (n == 0) ? cyc + 1 : 32'hFFFF_FFFF;
            push_exp(cyc + 1);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive(1'b0, 0, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        cyc++;
        #1;
        rst     = 1'b0;
        active  = 1'b0;
        acc     = 0;
        n_m     = 0;
        done_at = 32'hFFFF_FFFF;
        sb.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sc"}, sample_cnt, 0);
        chk({tag, "_err"}, err_cnt, 0);
        chk({tag, "_sum"}, sum_ed, 0);
        chk({tag, "_max"}, max_ed, 0);
        chk({tag, "_ready"}, in_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        vec_t tv [4];
        tv[0] = '{ex: 9,   ap: 7,   err: 1, sum: 2,  mx: 2, sq: 4};
        tv[1] = '{ex: 0,   ap: 0,   err: 1, sum: 2,  mx: 2, sq: 4};
        tv[2] = '{ex: 49,  ap: 57,  err: 2, sum: 10, mx: 8, sq: 68};
        tv[3] = '{ex: 225, ap: 225, err: 2, sum: 10, mx: 8, sq: 68};

        rst         = 1'b1;
        start       = 1'b0;
        num_samples = '0;
        in_valid    = 1'b0;
        exact_prod  = '0;
        approx_prod = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_zero("reset");

        // Exhaustive sweep with exact == approx.
        drive(1'b1, 256, 1'b0, 0, 0);
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                drive(1'b0, 0, 1'b1, a*b, a*b);
        idle(4);
        chk("t1_sc", sample_cnt, 256);
        chk("t1_err", err_cnt, 0);
        chk("t1_sum", sum_ed, 0);
        chk("t1_max", max_ed, 0);

        // Vector table: cumulative statistics after each pair.
        drive(1'b1, 4, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 0, 1'b1, tv[i].ex, tv[i].ap);
            idle(1);
            chk("t2_sc", sample_cnt, i + 1);
            chk("t2_err", err_cnt, tv[i].err);
            chk("t2_sum", sum_ed, tv[i].sum);
            chk("t2_max", max_ed, tv[i].mx);
`ifdef AXRM_SQ_ERR_EN
            chk("t2_sq", sum_sq_ed, tv[i].sq);
`endif
        end
        idle(3);
        chk("t2_done", done, 1);

        // Valid gaps, then surplus pairs that must be refused.
        drive(1'b1, 3, 1'b0, 0, 0);
        drive(1'b0, 0, 1'b1, 20, 21);
        drive(1'b0, 0, 1'b0, 0, 0);
        drive(1'b0, 0, 1'b1, 30, 30);
        drive(1'b0, 0, 1'b0, 0, 0);
        drive(1'b0, 0, 1'b1, 40, 44);
        drive(1'b0, 0, 1'b1, 50, 0);
        drive(1'b0, 0, 1'b1, 60, 0);
        idle(4);
        chk("t3_sc", sample_cnt, 3);
        chk("t3_max", max_ed, 4);

        // Zero-length run goes straight to DONE.
        drive(1'b1, 0, 1'b0, 0, 0);
        chk("t4_done", done, 1);
        chk("t4_sc", sample_cnt, 0);
        chk("t4_sum", sum_ed, 0);
        chk("t4_max", max_ed, 0);
        idle(2);

        // Reset mid-run discards in-flight pairs.
        drive(1'b1, 10, 1'b0, 0, 0);
        for (int i = 0; i < 5; i++) drive(1'b0, 0, 1'b1, i*3, i);
        do_reset();
        chk_zero("t5_rst");
        drive(1'b1, 2, 1'b0, 0, 0);
        drive(1'b0, 0, 1'b1, 5, 1);
        drive(1'b0, 0, 1'b1, 6, 6);
        idle(4);
        chk("t5_sc", sample_cnt, 2);
        chk("t5_err", err_cnt, 1);

        // Saturation on the narrow instance; start during RUN ignored.
        drive(1'b1, 4, 1'b0, 0, 0);
        drive(1'b0, 0, 1'b1, 100, 0);
        drive(1'b1, 7, 1'b1, 0, 100);
        drive(1'b0, 0, 1'b1, 100, 0);
        drive(1'b0, 0, 1'b1, 0, 100);
        idle(4);
        chk("t6_sum8", sum_ed2, 255);
        chk("t6_sum24", sum_ed, 400);
        chk("t6_sc", sample_cnt, 4);
        chk("t6_done", done, 1);
        chk("t6_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
